// File: rtl/gate_vector_checker_if.sv
// Handshake bundle between the sweep checker and the gate under test.
// The slave side is the checker; the master side owns start and the gate output.
interface gate_vector_checker_if #(
  parameter int N_IN = 2
);
  logic              start;
  logic [N_IN-1:0]   vec_out;
  logic              dut_y;
  logic              busy;
  logic              done;
  logic              pass;
  logic [N_IN:0]     err_count;
  logic              fail_valid;
  logic [N_IN-1:0]   first_fail_vec;

  modport master (
    output start, dut_y,
    input  vec_out, busy, done, pass, err_count, fail_valid, first_fail_vec
  );

  modport slave (
    input  start, dut_y,
    output vec_out, busy, done, pass, err_count, fail_valid, first_fail_vec
  );
endinterface

// File: rtl/gate_vector_checker.sv
// Sweeps every input vector onto a small combinational gate, holds it, then
// compares the gate output against EXPECT_TT and records count and first failure.
module gate_vector_checker #(
  parameter int                      N_IN        = 2,
  parameter int                      HOLD_CYCLES = 2,
  parameter logic [(2**N_IN)-1:0]    EXPECT_TT   = 4'b0001
) (
  input  logic                 clk,
  input  logic                 rst,
  gate_vector_checker_if.slave chk
);

  localparam int NVEC = 2**N_IN;
  localparam int HW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [N_IN-1:0] LAST_VEC  = N_IN'(NVEC - 1);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   vecOut_q, vecOut_d;
  logic [HW-1:0]     holdCnt_q, holdCnt_d;
  logic [N_IN:0]     errCount_q, errCount_d;
  logic              failValid_q, failValid_d;
  logic [N_IN-1:0]   firstFail_q, firstFail_d;
  logic              mismatch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      vecOut_q    <= '0;
      holdCnt_q   <= '0;
      errCount_q  <= '0;
      failValid_q <= 1'b0;
      firstFail_q <= '0;
    end else begin
      state_q     <= state_d;
      vecOut_q    <= vecOut_d;
      holdCnt_q   <= holdCnt_d;
      errCount_q  <= errCount_d;
      failValid_q <= failValid_d;
      firstFail_q <= firstFail_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    vecOut_d    = vecOut_q;
    holdCnt_d   = holdCnt_q;
    errCount_d  = errCount_q;
    failValid_d = failValid_q;
    firstFail_d = firstFail_q;
    // Case inequality so an undriven or X gate output is flagged, not masked.
    mismatch    = (chk.dut_y !== EXPECT_TT[vecOut_q]);

    case (state_q)
      IDLE, DONE: begin
        if (chk.start) begin
          state_d     = APPLY;
          vecOut_d    = '0;
          holdCnt_d   = '0;
          errCount_d  = '0;
          failValid_d = 1'b0;
          firstFail_d = '0;
        end
      end
      APPLY: begin
        if (holdCnt_q == HOLD_LAST) begin
          state_d = CHECK;
        end else begin
          holdCnt_d = holdCnt_q + 1'b1;
        end
      end
      CHECK: begin
        if (mismatch) begin
          errCount_d = errCount_q + 1'b1;
          if (!failValid_q) begin
            failValid_d = 1'b1;
            firstFail_d = vecOut_q;
          end
        end
        // The last vector exits to DONE, so the increment can never wrap.
        if (vecOut_q == LAST_VEC) begin
          state_d = DONE;
        end else begin
          vecOut_d  = vecOut_q + 1'b1;
          holdCnt_d = '0;
          state_d   = APPLY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decode registered state only; dut_y never reaches an output.
  assign chk.vec_out        = vecOut_q;
  assign chk.busy           = (state_q == APPLY) || (state_q == CHECK);
  assign chk.done           = (state_q == DONE);
  assign chk.pass           = (state_q == DONE) && (errCount_q == '0);
  assign chk.err_count      = errCount_q;
  assign chk.fail_valid     = failValid_q;
  assign chk.first_fail_vec = firstFail_q;

endmodule
